// File: rtl/pe_pkg.sv
// Shared types and constants for the pe_mac_cell processing element.
package pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } pe_state_e;

    localparam logic MODE_SERIAL   = 1'b0;
    localparam logic MODE_SYSTOLIC = 1'b1;

endpackage

// File: rtl/pe_mul_add.sv
// Combinational a*b + c with carry-out; PE_SAT_EN clamps the sum to all-ones on carry.
module pe_mul_add #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [ACC_W-1:0]  c_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W:0]      sum_full;

    always_comb begin
        prod     = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
        sum_full = {1'b0, c_i} + {1'b0, ACC_W'(prod)};
        carry_o  = sum_full[ACC_W];
`ifdef PE_SAT_EN
        // A clamped accumulator overflows again on any non-zero addend, so it stays clamped.
        sum_o    = carry_o ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
        sum_o    = sum_full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/pe_mac_cell.sv
// Dual-mode PE: serial output-stationary MAC over K beats, or systolic weight-stationary
// multiply-add. Optional clamping on overflow with PE_SAT_EN.
module pe_mac_cell
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int K_MAX  = 16,
    parameter int CNT_W  = $clog2(K_MAX + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mode_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  k_len_i,
    output logic              busy_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [ACC_W-1:0]  y_i,
    input  logic              w_load_i,
    output logic [DATA_W-1:0] a_o,
    output logic [ACC_W-1:0]  y_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              ovf_o,
    output pe_state_e         dbg_state_o
);

    // Handshake: a beat transfers on a cycle where in_valid_i && in_ready_o; a result
    // transfers where out_valid_o && out_ready_i (serial mode only).

    pe_state_e         state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [DATA_W-1:0] weight_q, weight_d;
    logic [DATA_W-1:0] a_out_q, a_out_d;
    logic [ACC_W-1:0]  y_out_q, y_out_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic              in_ready;

    logic              systolic;
    logic              k_ok;
    logic [DATA_W-1:0] ma_b;
    logic [ACC_W-1:0]  ma_c;
    logic [ACC_W-1:0]  ma_sum;
    logic              ma_carry;

    assign systolic = (state_q == ST_IDLE) && (mode_i == MODE_SYSTOLIC);
    assign k_ok     = (k_len_i != '0) && (k_len_i <= CNT_W'(K_MAX));

    // One multiply-add serves both modes; operand sources switch with the mode.
    assign ma_b = systolic ? weight_q : b_i;
    assign ma_c = systolic ? y_i : acc_q;

    pe_mul_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mul_add (
        .a_i     (a_i),
        .b_i     (ma_b),
        .c_i     (ma_c),
        .sum_o   (ma_sum),
        .carry_o (ma_carry)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            weight_q    <= '0;
            a_out_q     <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            weight_q    <= weight_d;
            a_out_q     <= a_out_d;
            y_out_q     <= y_out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        weight_d    = weight_q;
        a_out_d     = a_out_q;
        y_out_d     = y_out_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        in_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (mode_i == MODE_SYSTOLIC) begin
                    // A weight load takes the cycle; any beat offered alongside is refused.
                    if (w_load_i) begin
                        weight_d = b_i;
                    end else begin
                        in_ready = 1'b1;
                        if (in_valid_i) begin
                            a_out_d     = a_i;
                            y_out_d     = ma_sum;
                            out_valid_d = 1'b1;
                            ovf_d       = ovf_q | ma_carry;
                        end
                    end
                end else if (start_i && k_ok) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    k_d     = k_len_i;
                    ovf_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid_i) begin
                    acc_d   = ma_sum;
                    cnt_d   = cnt_q + CNT_W'(1);
                    a_out_d = a_i;
                    ovf_d   = ovf_q | ma_carry;
                    if (cnt_d == k_q) begin
                        y_out_d     = ma_sum;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign in_ready_o  = in_ready;
    assign a_o         = a_out_q;
    assign y_o         = y_out_q;
    assign out_valid_o = out_valid_q;
    assign ovf_o       = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pe_mac_cell.sv
// Directed self-checking bench for pe_mac_cell; a second instance with ACC_W=16 covers overflow.
module tb_pe_mac_cell;
    import pe_pkg::*;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        start;
    logic [4:0]  k_len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [19:0] y_in;
    logic        w_load;
    logic [7:0]  a_out;
    logic [19:0] y_out;
    logic        out_valid;
    logic        out_ready;
    logic        ovf;
    pe_state_e   state;

    logic        s_rst;
    logic        s_mode;
    logic        s_start;
    logic [4:0]  s_k_len;
    logic        s_busy;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_a;
    logic [7:0]  s_b;
    logic [15:0] s_y_in;
    logic        s_w_load;
    logic [7:0]  s_a_out;
    logic [15:0] s_y_out;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_ovf;
    pe_state_e   s_state;

    int n_cmp = 0;
    int n_err = 0;

    pe_mac_cell dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .start_i(start), .k_len_i(k_len),
        .busy_o(busy), .in_valid_i(in_valid), .in_ready_o(in_ready), .a_i(a), .b_i(b),
        .y_i(y_in), .w_load_i(w_load), .a_o(a_out), .y_o(y_out), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .ovf_o(ovf), .dbg_state_o(state)
    );

    pe_mac_cell #(.ACC_W(16)) dut16 (
        .clk_i(clk), .rst_i(s_rst), .mode_i(s_mode), .start_i(s_start), .k_len_i(s_k_len),
        .busy_o(s_busy), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .a_i(s_a), .b_i(s_b),
        .y_i(s_y_in), .w_load_i(s_w_load), .a_o(s_a_out), .y_o(s_y_out), .out_valid_o(s_out_valid),
        .out_ready_i(s_out_ready), .ovf_o(s_ovf), .dbg_state_o(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_rst = 1'b1;
        step(); step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (out_valid !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL reset_flags got ov=%b ovf=%b exp 0/0", out_valid, ovf); end
        n_cmp++; if (a_out !== 8'd0 || y_out !== 20'd0) begin n_err++; $display("FAIL reset_data got a=%0d y=%0d exp 0/0", a_out, y_out); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_cmp++; if (state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d exp %0d", state, ST_IDLE); end
        n_cmp++; if (s_y_out !== 16'd0 || s_ovf !== 1'b0) begin n_err++; $display("FAIL reset16 got y=%0d ovf=%b exp 0/0", s_y_out, s_ovf); end
        rst = 1'b0; s_rst = 1'b0;
        step();
    endtask

    task automatic test_serial();
        logic [7:0] av [9] = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3};
        logic [7:0] bv [9] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3};
        mode = MODE_SERIAL; out_ready = 1'b1;
        start = 1'b1; k_len = 5'd9;
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || state !== ST_ACC) begin n_err++; $display("FAIL serial_enter got busy=%b st=%0d exp 1/%0d", busy, state, ST_ACC); end
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1; a = av[i]; b = bv[i];
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL serial_in_ready beat %0d got %b exp 1", i, in_ready); end
            step();
            if (i < 8) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL serial_early_valid beat %0d got %b exp 0", i, out_valid); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || y_out !== 20'd36) begin n_err++; $display("FAIL serial_result got v=%b y=%0d exp 1/36", out_valid, y_out); end
        n_cmp++; if (ovf !== 1'b0 || in_ready !== 1'b0 || a_out !== 8'd3) begin n_err++; $display("FAIL serial_done got ovf=%b rdy=%b a=%0d exp 0/0/3", ovf, in_ready, a_out); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || state !== ST_IDLE) begin n_err++; $display("FAIL serial_idle got v=%b busy=%b st=%0d exp 0/0/0", out_valid, busy, state); end
    endtask

    task automatic test_systolic();
        mode = MODE_SYSTOLIC;
        w_load = 1'b1; b = 8'd3; in_valid = 1'b1; a = 8'd9; y_in = 20'd100;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL sys_wload_ready got %b exp 0", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || a_out === 8'd9) begin n_err++; $display("FAIL sys_wload_beat got v=%b a=%0d exp 0/not 9", out_valid, a_out); end
        w_load = 1'b0; b = 8'd0; a = 8'd2; y_in = 20'd5;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sys_ready got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (y_out !== 20'd11 || a_out !== 8'd2 || out_valid !== 1'b1) begin n_err++; $display("FAIL sys_result got y=%0d a=%0d v=%b exp 11/2/1", y_out, a_out, out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL sys_idle got v=%b busy=%b exp 0/0", out_valid, busy); end
        mode = MODE_SERIAL; y_in = 20'd0;
    endtask

    task automatic test_overflow();
        logic [15:0] exp_y;
`ifdef PE_SAT_EN
        exp_y = 16'd65535;
`else
        exp_y = 16'd64514;
`endif
        s_start = 1'b1; s_k_len = 5'd2;
        step();
        s_start = 1'b0; s_in_valid = 1'b1; s_a = 8'd255; s_b = 8'd255;
        step();
        n_cmp++; if (s_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_first got %b exp 0", s_ovf); end
        step();
        s_in_valid = 1'b0;
        n_cmp++; if (s_ovf !== 1'b1 || s_out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_flag got ovf=%b v=%b exp 1/1", s_ovf, s_out_valid); end
        n_cmp++; if (s_y_out !== exp_y) begin n_err++; $display("FAIL ovf_y got %0d exp %0d", s_y_out, exp_y); end
        step();
        n_cmp++; if (s_ovf !== 1'b1 || s_busy !== 1'b0) begin n_err++; $display("FAIL ovf_sticky got ovf=%b busy=%b exp 1/0", s_ovf, s_busy); end
        s_start = 1'b1; s_k_len = 5'd1;
        step();
        s_start = 1'b0;
        n_cmp++; if (s_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", s_ovf); end
        s_in_valid = 1'b1; s_a = 8'd1; s_b = 8'd1;
        step();
        s_in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start = 1'b1; k_len = 5'd1;
        step();
        start = 1'b0; in_valid = 1'b1; a = 8'd4; b = 8'd5;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; k_len = 5'd1; in_valid = 1'b1;
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", i, in_ready); end
            n_cmp++; if (out_valid !== 1'b1 || y_out !== 20'd20 || busy !== 1'b1) begin n_err++; $display("FAIL bp_hold cyc %0d got v=%b y=%0d busy=%b exp 1/20/1", i, out_valid, y_out, busy); end
            step();
        end
        start = 1'b0; in_valid = 1'b0;
        n_cmp++; if (state !== ST_DONE || y_out !== 20'd20) begin n_err++; $display("FAIL bp_still_done got st=%0d y=%0d exp %0d/20", state, y_out, ST_DONE); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0 || state !== ST_IDLE) begin n_err++; $display("FAIL bp_release got v=%b st=%0d exp 0/0", out_valid, state); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; k_len = 5'd1;
        step();
        start = 1'b0;
        n_cmp++; if (state !== ST_ACC) begin n_err++; $display("FAIL b2b_start got st=%0d exp %0d", state, ST_ACC); end
        in_valid = 1'b1; a = 8'd6; b = 8'd7;
        step();
        in_valid = 1'b0;
        n_cmp++; if (y_out !== 20'd42 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_result got y=%0d v=%b exp 42/1", y_out, out_valid); end
        step();
    endtask

    task automatic test_rst_mid();
        start = 1'b1; k_len = 5'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 8'd7; b = 8'd1;
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (a_out !== 8'd7 || busy !== 1'b1) begin n_err++; $display("FAIL rst_pre got a=%0d busy=%b exp 7/1", a_out, busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (a_out !== 8'd0 || y_out !== 20'd0 || out_valid !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL rst_mid got a=%0d y=%0d v=%b busy=%b ovf=%b exp zeros", a_out, y_out, out_valid, busy, ovf); end
        start = 1'b1; k_len = 5'd1;
        step();
        start = 1'b0; in_valid = 1'b1; a = 8'd2; b = 8'd2;
        step();
        in_valid = 1'b0;
        n_cmp++; if (y_out !== 20'd4 || out_valid !== 1'b1) begin n_err++; $display("FAIL rst_restart got y=%0d v=%b exp 4/1", y_out, out_valid); end
        step();
    endtask

    task automatic test_bad_klen();
        start = 1'b1; k_len = 5'd0;
        step();
        n_cmp++; if (busy !== 1'b0 || state !== ST_IDLE || out_valid !== 1'b0) begin n_err++; $display("FAIL klen0 got busy=%b st=%0d v=%b exp 0/0/0", busy, state, out_valid); end
        k_len = 5'd17;
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0 || state !== ST_IDLE) begin n_err++; $display("FAIL klen17 got busy=%b st=%0d exp 0/0", busy, state); end
        mode = MODE_SYSTOLIC; start = 1'b1; k_len = 5'd3;
        step();
        start = 1'b0; mode = MODE_SERIAL;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_systolic got busy=%b exp 0", busy); end
    endtask

    initial begin
        rst = 1'b1; mode = MODE_SERIAL; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a = '0; b = '0; y_in = '0; w_load = 1'b0; out_ready = 1'b1;
        s_rst = 1'b1; s_mode = MODE_SERIAL; s_start = 1'b0; s_k_len = '0; s_in_valid = 1'b0;
        s_a = '0; s_b = '0; s_y_in = '0; s_w_load = 1'b0; s_out_ready = 1'b1;
        test_reset();
        test_serial();
        test_systolic();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_rst_mid();
        test_bad_klen();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_mac_cell.md
# pe_mac_cell

Parametrised processing element for the matrix-multiply array; successor to the fixed 8-bit PE. Supports two run-time modes: serial output-stationary multiply-accumulate over a programmable length K, and systolic weight-stationary multiply-add with A pass-through. Adds valid/ready handshakes, a K-beat sequencer, a wider accumulator and overflow reporting. Sits as one tile in the PE grid, fed by the operand-skew buffers.

## Interface
- DATA_W, 8, operand width (a, b, weight), unsigned
- ACC_W, 20, accumulator / y width, unsigned; must be ≥ 2·DATA_W
- K_MAX, 16, maximum serial accumulation length
- CNT_W, $clog2(K_MAX+1), width of k_len and the beat counter

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = serial, 1 = systolic; sampled only in IDLE
- start  in  1  launch a serial accumulation (serial mode, IDLE only)
- k_len  in  CNT_W  beats to accumulate, valid range 1..K_MAX; sampled with start
- busy  out  1  high in ACC or DONE
- in_valid  in  1  a_in/b_in/y_in beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- a_in  in  DATA_W  A operand
- b_in  in  DATA_W  B operand (serial) / weight load data (systolic)
- y_in  in  ACC_W  partial sum from upstream PE (systolic)
- w_load  in  1  load b_in into weight register (systolic, IDLE)
- a_out  out  DATA_W  registered A pass-through to neighbour
- y_out  out  ACC_W  result
- out_valid  out  1  y_out valid
- out_ready  in  1  downstream accepts y_out (serial only)
- ovf  out  1  sticky overflow flag, cleared by rst or accepted start

## Operation
- States: IDLE, ACC, DONE (enum in package).
- IDLE, mode=0: in_ready=0. start with k_len in 1..K_MAX → acc←0, cnt←0, k_reg←k_len, ovf←0, →ACC. start with k_len=0 or >K_MAX ignored, stay IDLE.
- ACC: in_ready=1. Accepted beat: acc←acc + a_in·b_in, cnt←cnt+1, a_out←a_in. When accepted beat makes cnt==k_reg → DONE, y_out←final acc, out_valid←1.
- DONE: in_ready=0, out_valid=1, y_out held stable until out_ready. out_valid && out_ready → out_valid←0, →IDLE.
- IDLE, mode=1 (systolic): in_ready=1. w_load=1 → weight←b_in (w_load has priority over a simultaneous beat; the beat is not accepted, in_ready=0 that cycle). Accepted beat → a_out←a_in, y_out←y_in + a_in·weight, out_valid←1 next cycle; no beat → out_valid←0. out_ready ignored.
- start while busy or in mode=1: ignored. mode change while busy: ignored until IDLE.
- Arithmetic: product is 2·DATA_W bits, zero-extended to ACC_W; sum carry-out beyond ACC_W sets ovf.

## Timing
- Reset values: busy=0, in_ready=0, a_out=0, y_out=0, out_valid=0, ovf=0, weight=0, state=IDLE.
- rst mid-ACC/DONE: next cycle in reset state; partial acc discarded, no out_valid.
- Serial latency: out_valid rises the cycle after the K-th accepted beat; minimum total start→out_valid = K+1 cycles with in_valid held high.
- Systolic latency: 1 cycle, a_out and y_out aligned.
- Back-to-back serial: start accepted in the cycle after DONE handshake (IDLE), not in DONE.
- Gaps (in_valid=0) in ACC stall cnt, no penalty.

## Configuration
- PE_SAT_EN defined: on overflow acc/y_out clamp to 2^ACC_W−1 and remain clamped for the rest of the accumulation; ovf still set.
- PE_SAT_EN undefined: modulo-2^ACC_W wrap; ovf set.

## Structure
- Package pe_pkg: state enum (IDLE/ACC/DONE), mode constants MODE_SERIAL=0/MODE_SYSTOLIC=1.
- Sub-module pe_mul_add: combinational a·b + c with carry-out and PE_SAT_EN clamp, shared by both modes; FSM, counter and registers stay in pe_mac_cell.

## Test plan
- Serial K=9, beats (a,b) = (1,1)(2,1)(3,1)(1,2)(2,2)(3,2)(1,3)(2,3)(3,3), out_ready=1 → y_out=36, out_valid one cycle, ovf=0, back to IDLE.
- Systolic: w_load with b_in=3, then beat a_in=2, y_in=5 → next cycle y_out=11, a_out=2, out_valid=1; following idle cycle out_valid=0.
- Overflow, ACC_W=16, K=2, beats (255,255)×2 → ovf=1; y_out=64514 without PE_SAT_EN, 65535 with it.
- Backpressure: serial K=1 beat (4,5), out_ready low 3 cycles → out_valid and y_out=20 held, in_ready=0, start ignored; out_ready high → IDLE.
- rst asserted after 3 of K=5 beats → all outputs zero next cycle; new start K=1 beat (2,2) → y_out=4.
- start with k_len=0 → stays IDLE, busy=0, no out_valid.
